// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID/EX control stage: mode/opcode/EX command codes,
// FSM states and the registered control word.
package ctrl_pkg;

    localparam int CMD_W_DEF = 4;

    localparam logic [1:0] MODE_ARITH = 2'b00;
    localparam logic [1:0] MODE_MEM   = 2'b01;
    localparam logic [1:0] MODE_BR    = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EX_BR  = 4'b0000;
    localparam logic [3:0] EX_MOV = 4'b0001;
    localparam logic [3:0] EX_ADD = 4'b0010;
    localparam logic [3:0] EX_ADC = 4'b0011;
    localparam logic [3:0] EX_SUB = 4'b0100;
    localparam logic [3:0] EX_SBC = 4'b0101;
    localparam logic [3:0] EX_AND = 4'b0110;
    localparam logic [3:0] EX_ORR = 4'b0111;
    localparam logic [3:0] EX_EOR = 4'b1000;
    localparam logic [3:0] EX_MVN = 4'b1001;
    localparam logic [3:0] EX_MEM = 4'b1010;
    localparam logic [3:0] EX_CMP = 4'b1100;
    localparam logic [3:0] EX_TST = 4'b1110;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_BR_FLUSH = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] ex_cmd;
        logic       mem_r;
        logic       mem_w;
        logic       wb_en;
        logic       b;
        logic       sr_update;
        logic       with_src1;
    } ctrl_word_t;

    localparam int CTRL_W = $bits(ctrl_word_t);
    localparam ctrl_word_t NOP_WORD = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decode of {mode, op, s} into a control word plus an
// illegal flag; illegal encodings produce the all-zero NOP word.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic [3:0] op_i,
    input  logic       s_i,
    output ctrl_word_t word_o,
    output logic       illegal_o
);

    always_comb begin
        word_o    = NOP_WORD;
        illegal_o = 1'b0;
        case (mode_i)
            MODE_ARITH: begin
                word_o.valid     = 1'b1;
                word_o.wb_en     = 1'b1;
                word_o.with_src1 = 1'b1;
                word_o.sr_update = s_i;
                case (op_i)
                    OP_MOV: begin word_o.ex_cmd = EX_MOV; word_o.with_src1 = 1'b0; end
                    OP_MVN: begin word_o.ex_cmd = EX_MVN; word_o.with_src1 = 1'b0; end
                    OP_ADD: word_o.ex_cmd = EX_ADD;
                    OP_ADC: word_o.ex_cmd = EX_ADC;
                    OP_SUB: word_o.ex_cmd = EX_SUB;
                    OP_SBC: word_o.ex_cmd = EX_SBC;
                    OP_AND: word_o.ex_cmd = EX_AND;
                    OP_ORR: word_o.ex_cmd = EX_ORR;
                    OP_EOR: word_o.ex_cmd = EX_EOR;
                    OP_CMP: begin word_o.ex_cmd = EX_CMP; word_o.wb_en = 1'b0; end
                    OP_TST: begin word_o.ex_cmd = EX_TST; word_o.wb_en = 1'b0; end
                    default: begin
                        word_o    = NOP_WORD;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            MODE_MEM: begin
                // S selects load (read + writeback) versus store.
                word_o.valid     = 1'b1;
                word_o.ex_cmd    = EX_MEM;
                word_o.mem_r     = s_i;
                word_o.wb_en     = s_i;
                word_o.mem_w     = ~s_i;
                word_o.with_src1 = 1'b1;
            end
            MODE_BR: begin
                word_o.valid  = 1'b1;
                word_o.ex_cmd = EX_BR;
                word_o.b      = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID/EX control stage: registers the decoded control word and sequences
// multi-cycle memory waits and post-branch flush bubbles.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int CMD_W        = CMD_W_DEF,
    parameter int BR_FLUSH_CYC = 2,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             hazard,
    input  logic             S,
    input  logic [1:0]       mode,
    input  logic [3:0]       OP,
    input  logic             mem_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [CMD_W-1:0] EX_CMD,
    output logic             MEM_R,
    output logic             MEM_W,
    output logic             WB_EN,
    output logic             B,
    output logic             SR_update,
    output logic             with_src1,
    output logic             stall_req,
    output logic             flush_req,
    output logic             illegal_op,
    output logic             mem_err,
    output logic [1:0]       dbg_state_o
);

    localparam int CNT_MAX = (BR_FLUSH_CYC > MEM_TIMEOUT) ? BR_FLUSH_CYC : MEM_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_word_t       ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    ctrl_word_t       dec_word;
    logic             dec_illegal;
    logic             accept_slot;

    ctrl_decode u_decode (
        .mode_i    (mode),
        .op_i      (OP),
        .s_i       (S),
        .word_o    (dec_word),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        ctrl_d      = ctrl_q;
        illegal_d   = 1'b0;
        mem_err_d   = mem_err_q;
        in_ready    = 1'b0;
        stall_req   = 1'b0;
        flush_req   = 1'b0;
        accept_slot = 1'b0;
        case (state_q)
            ST_RUN: accept_slot = 1'b1;
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    accept_slot = 1'b1;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    stall_req = 1'b1;
                    mem_err_d = 1'b1;
                    ctrl_d    = NOP_WORD;
                    state_d   = ST_RUN;
                end else begin
                    stall_req = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            ST_BR_FLUSH: begin
                flush_req = 1'b1;
                ctrl_d    = NOP_WORD;
                if (cnt_q == CNT_W'(BR_FLUSH_CYC - 1)) state_d = ST_RUN;
                else                                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_RUN;
        endcase
        // Shared issue path for RUN and the completing MEM_WAIT cycle.
        if (accept_slot) begin
            in_ready = in_valid & ~hazard;
            state_d  = ST_RUN;
            if (in_ready) begin
                ctrl_d    = dec_word;
                illegal_d = dec_illegal;
                if (dec_word.mem_r | dec_word.mem_w) state_d = ST_MEM_WAIT;
                else if (dec_word.b)                 state_d = ST_BR_FLUSH;
            end else begin
                ctrl_d = NOP_WORD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            ctrl_q    <= NOP_WORD;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign out_valid   = ctrl_q.valid;
    assign EX_CMD      = CMD_W'(ctrl_q.ex_cmd);
    assign MEM_R       = ctrl_q.mem_r;
    assign MEM_W       = ctrl_q.mem_w;
    assign WB_EN       = ctrl_q.wb_en;
    assign B           = ctrl_q.b;
    assign SR_update   = ctrl_q.sr_update;
    assign with_src1   = ctrl_q.with_src1;
    assign illegal_op  = illegal_q;
    assign mem_err     = mem_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: decode table, memory wait/timeout,
// branch flush, illegal pulses and asynchronous reset.
module tb_ctrl_pipe_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, hazard, S, mem_ready;
    logic [1:0] mode;
    logic [3:0] OP;
    logic       in_ready, out_valid, MEM_R, MEM_W, WB_EN, B, SR_update, with_src1;
    logic       stall_req, flush_req, illegal_op, mem_err;
    logic [3:0] EX_CMD;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_pipe_unit #(.CMD_W(4), .BR_FLUSH_CYC(2), .MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .hazard     (hazard),
        .S          (S),
        .mode       (mode),
        .OP         (OP),
        .mem_ready  (mem_ready),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .EX_CMD     (EX_CMD),
        .MEM_R      (MEM_R),
        .MEM_W      (MEM_W),
        .WB_EN      (WB_EN),
        .B          (B),
        .SR_update  (SR_update),
        .with_src1  (with_src1),
        .stall_req  (stall_req),
        .flush_req  (flush_req),
        .illegal_op (illegal_op),
        .mem_err    (mem_err),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Expected control word layout: {valid, ex[3:0], mem_r, mem_w, wb_en, b, sr, src1}
    function automatic logic [10:0] mkw(input logic v, input logic [3:0] ex, input logic mr,
                                        input logic mw, input logic wb, input logic b,
                                        input logic sr, input logic src);
        return {v, ex, mr, mw, wb, b, sr, src};
    endfunction

    function automatic logic [10:0] obs_word();
        return {out_valid, EX_CMD, MEM_R, MEM_W, WB_EN, B, SR_update, with_src1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic s, input logic [1:0] m,
                         input logic [3:0] op, input logic mr);
        in_valid = v; hazard = h; S = s; mode = m; OP = op; mem_ready = mr;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] w_nop, w_add_s1, w_add_s0, w_mov, w_cmp, w_ldr, w_str, w_br;

    initial begin
        w_nop    = '0;
        w_add_s1 = mkw(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        w_add_s0 = mkw(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        w_mov    = mkw(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        w_cmp    = mkw(1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        w_ldr    = mkw(1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        w_str    = mkw(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        w_br     = mkw(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0);
        #2;
        chk("rst_word", obs_word(), w_nop);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_illegal", illegal_op, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // ADD S=1
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'b0100, 1'b0);
        #1 chk("add_in_ready", in_ready, 1'b1);
        cycle();
        chk("add_word", obs_word(), w_add_s1);

        // SUB blocked by hazard -> bubble
        drive(1'b1, 1'b1, 1'b0, 2'b00, 4'b0010, 1'b0);
        #1 chk("haz_in_ready", in_ready, 1'b0);
        cycle();
        chk("haz_bubble", obs_word(), w_nop);

        // MOV and CMP
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0);
        cycle();
        chk("mov_word", obs_word(), w_mov);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'b1010, 1'b0);
        cycle();
        chk("cmp_word", obs_word(), w_cmp);

        // Undefined arith OP, then idle, then mode 11
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'b0111, 1'b0);
        cycle();
        chk("ill_op_word", obs_word(), w_nop);
        chk("ill_op_pulse", illegal_op, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 4'b0111, 1'b0);
        cycle();
        chk("ill_op_clear", illegal_op, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'b11, 4'b0100, 1'b0);
        cycle();
        chk("ill_mode_word", obs_word(), w_nop);
        chk("ill_mode_pulse", illegal_op, 1'b1);

        // mem_ready outside MEM_WAIT is ignored
        drive(1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1);
        cycle();
        chk("mr_ignored_state", dbg_state, 2'd0);
        chk("mr_ignored_ill", illegal_op, 1'b0);

        // LDR, mem_ready on the 4th wait cycle; ADD waits in decode
        drive(1'b1, 1'b0, 1'b1, 2'b01, 4'b0000, 1'b0);
        cycle();
        chk("ldr_word", obs_word(), w_ldr);
        chk("ldr_state", dbg_state, 2'd1);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldr_wait_stall", stall_req, 1'b1);
            chk("ldr_wait_ready", in_ready, 1'b0);
            chk("ldr_wait_word", obs_word(), w_ldr);
            chk("ldr_wait_ill", illegal_op, 1'b0);
            cycle();
        end
        mem_ready = 1'b1;
        #1;
        chk("ldr_done_stall", stall_req, 1'b0);
        chk("ldr_done_ready", in_ready, 1'b1);
        chk("ldr_done_word", obs_word(), w_ldr);
        cycle();
        chk("ldr_next_word", obs_word(), w_add_s0);
        chk("ldr_next_state", dbg_state, 2'd0);

        // Branch: two flush cycles drop the pending ADD, then it issues
        drive(1'b1, 1'b0, 1'b0, 2'b10, 4'b0000, 1'b0);
        cycle();
        chk("br_word", obs_word(), w_br);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'b0100, 1'b0);
        #1;
        chk("br_flush1", flush_req, 1'b1);
        chk("br_ready1", in_ready, 1'b0);
        cycle();
        chk("br_bubble1", obs_word(), w_nop);
        chk("br_flush2", flush_req, 1'b1);
        chk("br_ready2", in_ready, 1'b0);
        cycle();
        chk("br_bubble2", obs_word(), w_nop);
        chk("br_flush_end", flush_req, 1'b0);
        chk("br_ready_end", in_ready, 1'b1);
        cycle();
        chk("br_after_word", obs_word(), w_add_s1);

        // Store with no mem_ready -> timeout after 16 wait cycles
        drive(1'b1, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0);
        cycle();
        chk("str_word", obs_word(), w_str);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("str_wait_stall", stall_req, 1'b1);
            chk("str_wait_err", mem_err, 1'b0);
            chk("str_wait_word", obs_word(), w_str);
            cycle();
        end
        chk("str_to_err", mem_err, 1'b1);
        chk("str_to_word", obs_word(), w_nop);
        chk("str_to_state", dbg_state, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'b0100, 1'b0);
        cycle();
        chk("str_resume_word", obs_word(), w_add_s1);
        chk("str_err_sticky", mem_err, 1'b1);

        // hazard together with mem_ready: mem op completes, bubble loaded
        drive(1'b1, 1'b0, 1'b1, 2'b01, 4'b0000, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 4'b0100, 1'b1);
        #1 chk("hz_mr_ready", in_ready, 1'b0);
        cycle();
        chk("hz_mr_word", obs_word(), w_nop);
        chk("hz_mr_state", dbg_state, 2'd0);

        // Reset in the middle of MEM_WAIT
        drive(1'b1, 1'b0, 1'b1, 2'b01, 4'b0000, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0);
        cycle();
        chk("rst_mid_pre", dbg_state, 2'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_word", obs_word(), w_nop);
        chk("rst_mid_state", dbg_state, 2'd0);
        chk("rst_mid_err", mem_err, 1'b0);
        chk("rst_mid_stall", stall_req, 1'b0);
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'b0100, 1'b0);
        cycle();
        chk("rst_after_word", obs_word(), w_add_s1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
